uart_msg_sender: RTL and testbench

Parametrised successor to the fixed-string UART greeter. Streams a compile-time message of MSG_LEN bytes into an external txuart byte transmitter using its tx_wr/busy handshake. Supports one-shot send on start, or continuous repeat with a programmable idle gap, plus synchronous abort. Sits between top-level control logic and txuart.

---
 rtl/uart_msg_pkg.sv | 37 +++
 rtl/uart_msg_gap_timer.sv | 30 +++
 rtl/uart_msg_sender.sv | 147 ++++++++++++++
 tb/tb_uart_msg_sender.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_msg_pkg.sv
// Shared definitions for uart_msg_sender: FSM state encoding, ASCII line
// terminators and the message byte selector.
package uart_msg_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    ACK  = 3'd2,
    WAIT = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;

  // Messages are zero-extended into this fixed width before byte selection.
  localparam int MSG_MAX_LEN  = 64;
  localparam int MSG_MAX_BITS = 8 * MSG_MAX_LEN;

  // Byte 0 is the most-significant byte; idx == len / len+1 yield CR / LF.
  function automatic logic [7:0] byte_at(input logic [MSG_MAX_BITS-1:0] msg,
                                         input int unsigned idx,
                                         input int unsigned len);
    logic [MSG_MAX_BITS-1:0] shifted;
    byte_at = 8'h00;
    shifted = '0;
    if (idx < len) begin
      shifted = msg >> (8 * (len - 1 - idx));
      byte_at = shifted[7:0];
    end else if (idx == len) begin
      byte_at = CHR_CR;
    end else if (idx == len + 1) begin
      byte_at = CHR_LF;
    end
  endfunction

endpackage

// File: rtl/uart_msg_gap_timer.sv
// Loadable down-counter timing the idle gap between repeated messages;
// counts down to zero on its own once loaded and then holds.
module uart_msg_gap_timer #(
  parameter int GAP_CYCLES = 255,
  parameter int GAP_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  output logic expired
);

  logic [GAP_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= GAP_W'(GAP_CYCLES);
    end else if (count_reg != '0) begin
      count_reg <= count_reg - GAP_W'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/uart_msg_sender.sv
// Streams a compile-time message into a txuart via tx_wr/busy, one-shot or
// repeating with an idle gap. Define UART_MSG_CRLF_EN to append CR LF.
module uart_msg_sender
  import uart_msg_pkg::*;
#(
  parameter int                   MSG_LEN    = 6,
  parameter logic [8*MSG_LEN-1:0] MSG        = "hello ",
  parameter int                   GAP_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       repeat_en,
  input  logic       abort,
  input  logic       busy,
  output logic       tx_wr,
  output logic [7:0] tx_data,
  output logic       active,
  output logic       done
);

  localparam int IDX_W = $clog2(MSG_LEN + 2);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
`ifdef UART_MSG_CRLF_EN
  localparam int LAST = MSG_LEN + 1;
`else
  localparam int LAST = MSG_LEN - 1;
`endif
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(LAST);
  localparam logic [MSG_MAX_BITS-1:0] MSG_EXT  = MSG_MAX_BITS'(MSG);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             tx_wr_reg, tx_wr_next;
  logic [7:0]       tx_data_reg, tx_data_next;
  logic             active_reg, active_next;
  logic             done_reg, done_next;
  logic             gap_load, gap_clear, gap_expired;

  uart_msg_gap_timer #(
    .GAP_CYCLES (GAP_CYCLES),
    .GAP_W      (GAP_W)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (gap_load),
    .clear   (gap_clear),
    .expired (gap_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      tx_wr_reg   <= 1'b0;
      tx_data_reg <= 8'h00;
      active_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      tx_wr_reg   <= tx_wr_next;
      tx_data_reg <= tx_data_next;
      active_reg  <= active_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    tx_wr_next   = 1'b0;
    tx_data_next = tx_data_reg;
    active_next  = active_reg;
    done_next    = 1'b0;
    gap_load     = 1'b0;
    gap_clear    = 1'b0;
    if (abort) begin
      state_next  = IDLE;
      idx_next    = '0;
      active_next = 1'b0;
      gap_clear   = 1'b0 | 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          // active lingers for the done cycle, so a start there is still ignored
          active_next = 1'b0;
          if (start && !active_reg) begin
            state_next  = SEND;
            idx_next    = '0;
            active_next = 1'b1;
          end
        end
        SEND: begin
          if (!busy) begin
            tx_wr_next   = 1'b1;
            tx_data_next = byte_at(MSG_EXT, 32'(idx_reg), MSG_LEN);
            state_next   = ACK;
          end
        end
        ACK: begin
          // busy only rises the cycle after tx_wr is accepted
          state_next = WAIT;
        end
        WAIT: begin
          if (!busy) begin
            if (idx_reg != LAST_IDX) begin
              idx_next   = idx_reg + IDX_W'(1);
              state_next = SEND;
            end else begin
              done_next = 1'b1;
              idx_next  = '0;
              if (repeat_en) begin
                state_next = GAP;
                gap_load   = 1'b1;
              end else begin
                state_next = IDLE;
              end
            end
          end
        end
        GAP: begin
          if (gap_expired) begin
            idx_next = '0;
            if (repeat_en) begin
              state_next = SEND;
            end else begin
              state_next  = IDLE;
              active_next = 1'b0;
            end
          end
        end
        default: begin
          state_next  = IDLE;
          idx_next    = '0;
          active_next = 1'b0;
        end
      endcase
    end
  end

  assign tx_wr   = tx_wr_reg;
  assign tx_data = tx_data_reg;
  assign active  = active_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_uart_msg_sender.sv
// Bench for uart_msg_sender: table of message scenarios on a "hello " instance
// (gap 3) plus hand sequences for collisions, async reset and a gap-0 instance.
module tb_uart_msg_sender;

`ifdef UART_MSG_CRLF_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int NB_A     = 6 + EXTRA;
  localparam int NB_B     = 1 + EXTRA;
  localparam int GAP_A    = 3;
  localparam int BUSY_LEN = 10;
  localparam int BUDGET   = 260;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start_a = 1'b0, repeat_a = 1'b0, abort_a = 1'b0, busy_a = 1'b0;
  logic       tx_wr_a, active_a, done_a;
  logic [7:0] tx_data_a;
  logic       start_b = 1'b0, repeat_b = 1'b0, abort_b = 1'b0, busy_b = 1'b0;
  logic       tx_wr_b, active_b, done_b;
  logic [7:0] tx_data_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_a [8] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h0D, 8'h0A};
  logic [7:0] exp_b [3] = '{8'h41, 8'h0D, 8'h0A};

  uart_msg_sender #(.MSG_LEN(6), .MSG("hello "), .GAP_CYCLES(GAP_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .repeat_en(repeat_a), .abort(abort_a),
    .busy(busy_a), .tx_wr(tx_wr_a), .tx_data(tx_data_a), .active(active_a), .done(done_a)
  );

  uart_msg_sender #(.MSG_LEN(1), .MSG("A"), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .repeat_en(repeat_b), .abort(abort_b),
    .busy(busy_b), .tx_wr(tx_wr_b), .tx_data(tx_data_b), .active(active_b), .done(done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // txuart models: busy rises the cycle after tx_wr and stays high BUSY_LEN cycles
  int busy_cnt_a = 0, busy_cnt_b = 0;
  always @(posedge clk) begin
    if (tx_wr_a) begin busy_a <= 1'b1; busy_cnt_a <= BUSY_LEN; end
    else if (busy_cnt_a > 1) busy_cnt_a <= busy_cnt_a - 1;
    else begin busy_a <= 1'b0; busy_cnt_a <= 0; end
    if (tx_wr_b) begin busy_b <= 1'b1; busy_cnt_b <= BUSY_LEN; end
    else if (busy_cnt_b > 1) busy_cnt_b <= busy_cnt_b - 1;
    else begin busy_b <= 1'b0; busy_cnt_b <= 0; end
  end

  int         wr_q_a[$], done_q_a[$], wr_q_b[$], done_q_b[$];
  logic [7:0] data_q_a[$], data_q_b[$];
  logic       act_done_a[$], act_after_a[$];
  logic       prev_wr_a = 1'b0, prev_done_a = 1'b0;
  logic [7:0] prev_data_a = 8'h00;

  always @(negedge clk) begin
    if (tx_wr_a) begin
      wr_q_a.push_back(cyc);
      data_q_a.push_back(tx_data_a);
      checks++;
      if (prev_wr_a) begin
        errors++;
        $display("FAIL wr_single_a: tx_wr high on consecutive cycles at %0d, required one-cycle strobe", cyc);
      end
    end else if (!rst) begin
      checks++;
      if (tx_data_a != prev_data_a) begin
        errors++;
        $display("FAIL data_hold_a: tx_data changed to %0h from %0h without tx_wr at %0d", tx_data_a, prev_data_a, cyc);
      end
    end
    if (done_a) begin
      done_q_a.push_back(cyc);
      act_done_a.push_back(active_a);
    end
    if (prev_done_a) act_after_a.push_back(active_a);
    prev_wr_a   <= tx_wr_a;
    prev_done_a <= done_a;
    prev_data_a <= tx_data_a;
    if (tx_wr_b) begin wr_q_b.push_back(cyc); data_q_b.push_back(tx_data_b); end
    if (done_b) done_q_b.push_back(cyc);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_a();
    wr_q_a.delete(); data_q_a.delete(); done_q_a.delete();
    act_done_a.delete(); act_after_a.delete();
  endtask

  task automatic wait_idle_a();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (!active_a && !busy_a) begin ok = 1'b1; break; end
      step();
    end
    chk("wait_idle_a", int'(ok), 1);
  endtask

  typedef struct packed {
    logic rep;
    int   abort_after;
    int   drop_after;
    int   restart_after;
    int   exp_bytes;
    int   exp_done;
  } vec_t;

  vec_t  vecs [4];
  string vname [4];
  int    n, start_cyc, nb, lat;
  bit    aborted, abort_pending, restarted, poked, ok;

  initial begin
    vname[0] = "oneshot"; vecs[0] = '{1'b0, 0, 0, 0, NB_A, 1};
    vname[1] = "abort3";  vecs[1] = '{1'b0, 3, 0, 0, 3, 0};
    vname[2] = "restart"; vecs[2] = '{1'b0, 0, 0, 2, NB_A, 1};
    vname[3] = "repeat2"; vecs[3] = '{1'b1, 0, NB_A + 2, 0, 2 * NB_A, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_wr", int'(tx_wr_a), 0);
    chk("rst_tx_data", int'(tx_data_a), 0);
    chk("rst_active", int'(active_a), 0);
    chk("rst_done", int'(done_a), 0);
    step();
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      wait_idle_a();
      clear_a();
      repeat_a = vecs[v].rep;
      start_cyc = cyc;
      start_a = 1'b1;
      step();
      aborted = 0; abort_pending = 0; restarted = 0; poked = 0;
      for (int c = 0; c < BUDGET; c++) begin
        start_a = 1'b0;
        abort_a = 1'b0;
        if (abort_pending) begin
          chk({vname[v], "_abort_active"}, int'(active_a), 0);
          chk({vname[v], "_abort_tx_wr"}, int'(tx_wr_a), 0);
          abort_pending = 0;
        end
        n = wr_q_a.size();
        if (vecs[v].abort_after != 0 && !aborted && n == vecs[v].abort_after && n > 0 && cyc == wr_q_a[n-1] + 5) begin
          abort_a = 1'b1; aborted = 1; abort_pending = 1;
        end
        if (vecs[v].restart_after != 0 && !restarted && n == vecs[v].restart_after && n > 0 && cyc == wr_q_a[n-1] + 5) begin
          start_a = 1'b1; restarted = 1;
        end
        if (vecs[v].rep && !poked && done_q_a.size() == 1 && cyc == done_q_a[0] + 2) begin
          start_a = 1'b1; poked = 1;
        end
        if (vecs[v].drop_after != 0 && n >= vecs[v].drop_after) repeat_a = 1'b0;
        step();
      end
      start_a = 1'b0;
      abort_a = 1'b0;
      repeat_a = 1'b0;

      nb = wr_q_a.size();
      chk({vname[v], "_bytes"}, nb, vecs[v].exp_bytes);
      for (int i = 0; i < nb && i < vecs[v].exp_bytes; i++)
        chk($sformatf("%s_byte%0d", vname[v], i), int'(data_q_a[i]), int'(exp_a[i % NB_A]));
      chk({vname[v], "_done"}, done_q_a.size(), vecs[v].exp_done);
      lat = (nb > 0) ? wr_q_a[0] - start_cyc : -1;
      chk({vname[v], "_latency"}, lat, 2);
      if (vecs[v].exp_bytes >= 2)
        chk({vname[v], "_byte_spacing"}, (nb >= 2) ? wr_q_a[1] - wr_q_a[0] : -1, 13);
      if (vecs[v].exp_done > 0)
        chk({vname[v], "_done_delay"},
            (nb >= NB_A && done_q_a.size() > 0) ? done_q_a[0] - wr_q_a[NB_A-1] : -1, 12);
      if (!vecs[v].rep && vecs[v].exp_done > 0) begin
        chk({vname[v], "_active_at_done"}, (act_done_a.size() > 0) ? int'(act_done_a[0]) : -1, 1);
        chk({vname[v], "_active_after_done"}, (act_after_a.size() > 0) ? int'(act_after_a[0]) : -1, 0);
      end
      if (vecs[v].rep && vecs[v].exp_bytes > NB_A)
        chk({vname[v], "_gap"},
            (nb > NB_A && done_q_a.size() > 0) ? wr_q_a[NB_A] - done_q_a[0] : -1, GAP_A + 2);
      chk({vname[v], "_end_active"}, int'(active_a), 0);
      $display("vector %s: bytes=%0d done=%0d", vname[v], nb, done_q_a.size());
    end

    // start and abort together while idle: abort wins
    wait_idle_a();
    clear_a();
    start_a = 1'b1; abort_a = 1'b1;
    step();
    start_a = 1'b0; abort_a = 1'b0;
    chk("collide_active", int'(active_a), 0);
    repeat (30) step();
    chk("collide_no_wr", wr_q_a.size(), 0);
    $display("sequence collide: bytes=%0d", wr_q_a.size());

    // asynchronous reset while in the gap
    wait_idle_a();
    clear_a();
    repeat_a = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (done_q_a.size() >= 1) begin ok = 1; break; end
    end
    chk("rstgap_reached_gap", int'(ok), 1);
    step();
    chk("rstgap_pre_active", int'(active_a), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rstgap_tx_wr", int'(tx_wr_a), 0);
    chk("rstgap_tx_data", int'(tx_data_a), 0);
    chk("rstgap_active", int'(active_a), 0);
    chk("rstgap_done", int'(done_a), 0);
    step();
    rst = 1'b0;
    clear_a();
    repeat (40) step();
    chk("rstgap_no_wr", wr_q_a.size(), 0);
    chk("rstgap_idle", int'(active_a), 0);
    repeat_a = 1'b0;
    $display("sequence async_reset: bytes_after=%0d", wr_q_a.size());

    // gap of zero cycles on the single-byte instance
    repeat_b = 1'b1;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (done_q_b.size() >= 2) repeat_b = 1'b0;
      step();
    end
    repeat_b = 1'b0;
    chk("gap0_bytes", wr_q_b.size(), 2 * NB_B);
    for (int i = 0; i < wr_q_b.size() && i < 2 * NB_B; i++)
      chk($sformatf("gap0_byte%0d", i), int'(data_q_b[i]), int'(exp_b[i % NB_B]));
    chk("gap0_done", done_q_b.size(), 2);
    chk("gap0_gap", (wr_q_b.size() > NB_B && done_q_b.size() > 0) ? wr_q_b[NB_B] - done_q_b[0] : -1, 2);
    chk("gap0_end_active", int'(active_b), 0);
    $display("sequence gap0: bytes=%0d done=%0d", wr_q_b.size(), done_q_b.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
